// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg : shared BCD digit types for the TOD counter chain.
// Rev 1.0
// ============================================================================
package bcd_pkg;

   localparam int BCD_NIBBLE_W = 4;

   typedef logic [BCD_NIBBLE_W-1:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t d;
      logic       c;
   } bcd_step_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// bcd_digit_step : one BCD digit's next value and carry/borrow, combinational.
// Rev 1.0
// ============================================================================
module bcd_digit_step
   import bcd_pkg::*;
(
   input  bcd_digit_t d,
   input  bcd_digit_t dmax,
   input  logic       en,
   input  logic       down,
   output bcd_digit_t q,
   output logic       co
);

   bcd_step_t step;

   // Out-of-range nibbles never equal dmax, so counting up they wrap mod 16 silently.
   always_comb begin
      step = '{d: d, c: 1'b0};
      if (en) begin
         if (!down) begin
            if (d == dmax) step = '{d: '0, c: 1'b1};
            else           step.d = d + 4'd1;
         end else begin
            if (d == '0)   step = '{d: dmax, c: 1'b1};
            else           step.d = d - 4'd1;
         end
      end
   end

   assign q  = step.d;
   assign co = step.c;

endmodule
`default_nettype wire

// File: rtl/bcd_counter_chain.sv
`default_nettype none
// ============================================================================
// bcd_counter_chain : multi-digit BCD up/down counter with load, snapshot,
// alarm compare and terminal carry pulse. Rev 1.0
// ============================================================================
module bcd_counter_chain
   import bcd_pkg::*;
#(
   parameter int          NDIG      = 4,
   parameter logic [31:0] DMAX      = 32'h5959,
   parameter logic [31:0] RESET_VAL = 32'h0000
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tick,
   input  logic                         run,
   input  logic                         dir_down,
   input  logic                         ld,
   input  logic [NDIG*BCD_NIBBLE_W-1:0] ld_val,
   input  logic                         freeze,
   input  logic [NDIG*BCD_NIBBLE_W-1:0] alarm_val,
   output logic [NDIG*BCD_NIBBLE_W-1:0] count,
   output logic [NDIG*BCD_NIBBLE_W-1:0] rd_val,
   output logic                         alarm_hit,
   output logic                         cout
);

   localparam int          W     = NDIG * BCD_NIBBLE_W;
   localparam logic [W-1:0] RST_V = RESET_VAL[W-1:0];

   logic [W-1:0]  count_q, count_d, rd_q, rd_d, step_val;
   logic [NDIG:0] carry;
   logic          step_en, wr;
   logic          alarm_q, alarm_d, cout_q, cout_d, armed_q;

   assign step_en  = tick & run & ~ld;
   assign carry[0] = step_en;

   generate
      for (genvar i = 0; i < NDIG; i++) begin : g_digit
         bcd_digit_step u_step (
            .d    (count_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .dmax (DMAX[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .en   (carry[i]),
            .down (dir_down),
            .q    (step_val[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .co   (carry[i+1])
         );
      end
   endgenerate

   // armed_q masks both pulses on the first clock after reset release.
   always_comb begin
      count_d = count_q;
      cout_d  = 1'b0;
      wr      = 1'b0;
      if (ld) begin
         count_d = ld_val;
         wr      = 1'b1;
      end else if (step_en) begin
         count_d = step_val;
         cout_d  = carry[NDIG];
         wr      = 1'b1;
      end
      alarm_d = armed_q & wr & (count_d == alarm_val);
      cout_d  = cout_d & armed_q;
      rd_d    = freeze ? rd_q : count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= RST_V;
         rd_q    <= RST_V;
         alarm_q <= 1'b0;
         cout_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         count_q <= count_d;
         rd_q    <= rd_d;
         alarm_q <= alarm_d;
         cout_q  <= cout_d;
         armed_q <= 1'b1;
      end
   end

   assign count     = count_q;
   assign rd_val    = rd_q;
   assign alarm_hit = alarm_q;
   assign cout      = cout_q;

endmodule
`default_nettype wire
